// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light monitor slice.
// Contents: lamp codes, the phase enum P1..P6 with a next-phase helper, the
// six-entry legal pattern table, default dwell constants, and the monitor
// state enum.
package tl_pkg;

  // Lamp codes (one-hot per approach)
  localparam logic [2:0] GREEN = 3'b001;
  localparam logic [2:0] AMBER = 3'b010;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [2:0] {
    P1 = 3'd0,
    P2 = 3'd1,
    P3 = 3'd2,
    P4 = 3'd3,
    P5 = 3'd4,
    P6 = 3'd5
  } phase_e;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  // Default dwell lengths in clk cycles and the dwell counter width
  localparam int T_P1_DEF = 7;
  localparam int T_P2_DEF = 2;
  localparam int T_P3_DEF = 5;
  localparam int T_P4_DEF = 2;
  localparam int T_P5_DEF = 3;
  localparam int T_P6_DEF = 2;
  localparam int DW_DEF   = 8;

  // Legal patterns as {M1, M2, MT, S}; element [n] holds phase P(n+1).
  localparam logic [5:0][11:0] PATTERN_TABLE = {
    {RED,   RED,   RED,   AMBER},  // P6
    {RED,   RED,   RED,   GREEN},  // P5
    {AMBER, RED,   AMBER, RED  },  // P4
    {GREEN, RED,   GREEN, RED  },  // P3
    {GREEN, AMBER, RED,   RED  },  // P2
    {GREEN, GREEN, RED,   RED  }   // P1
  };

  // Successor in the rotation P1..P6, wrapping P6 -> P1
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    next_phase = (p == P6) ? 3'(P1) : p + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Four-approach light bus between the intersection controller and the monitor.
// Signals: light_M1, light_M2, light_MT, light_S, 3-bit one-hot lamp codes each.
// Modports: master = controller (drives lamps), slave = monitor (samples lamps).
interface traffic_light_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;

  modport master (output light_M1, light_M2, light_MT, light_S);
  modport slave  (input  light_M1, light_M2, light_MT, light_S);
endinterface

// File: rtl/tl_pattern_decoder.sv
// Combinational lamp-pattern decoder.
// Ports:
//   lamps  in  12  {M1, M2, MT, S} lamp codes
//   legal  out 1   pattern matches one of P1..P6
//   phase  out 3   matching phase index 0..5, 0 when not legal
module tl_pattern_decoder
  import tl_pkg::*;
(
  input  logic [11:0] lamps,
  output logic        legal,
  output logic [2:0]  phase
);

  logic [5:0] hit;

  for (genvar gi = 0; gi < 6; gi++) begin : g_match
    assign hit[gi] = (lamps == PATTERN_TABLE[gi]);
  end

  // Table entries are mutually exclusive, so at most one hit bit is set.
  always_comb begin
    legal = |hit;
    phase = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (hit[i]) phase = 3'(i);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the four-approach light bus. Decodes each sample to
// a phase, times the dwell of each phase, and raises sticky flags for illegal
// patterns, out-of-order transitions and wrong dwell lengths.
// Optional feature macro: TLM_ERR_CAPTURE_EN (latch phase/dwell at first error).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   lights       light bus (slave modport)
//   clr_err      synchronous clear of sticky flags
//   phase        decoded phase of current sample (0 when illegal)
//   phase_vld    1 while tracking
//   err_illegal, err_order, err_timing   sticky flags
//   cycle_cnt    completed error-free P6->P1 transitions
//   err_phase, err_dwell   capture at first error (0 without the macro)
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int T_P1 = T_P1_DEF,
  parameter int T_P2 = T_P2_DEF,
  parameter int T_P3 = T_P3_DEF,
  parameter int T_P4 = T_P4_DEF,
  parameter int T_P5 = T_P5_DEF,
  parameter int T_P6 = T_P6_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  traffic_light_monitor_if.slave        lights,
  input  logic                          clr_err,
  output logic [2:0]                    phase,
  output logic                          phase_vld,
  output logic                          err_illegal,
  output logic                          err_order,
  output logic                          err_timing,
  output logic [15:0]                   cycle_cnt,
  output logic [2:0]                    err_phase,
  output logic [DW-1:0]                 err_dwell
);

  logic       legal;
  logic [2:0] dec_phase;

  tl_pattern_decoder u_dec (
    .lamps ({lights.light_M1, lights.light_M2, lights.light_MT, lights.light_S}),
    .legal (legal),
    .phase (dec_phase)
  );

  mon_state_e    state, state_next;
  logic [2:0]    prev, prev_next;
  logic [DW-1:0] dwell, dwell_next;
  // timed=0 marks a dwell that began mid-phase after an illegal-pattern resync
  logic          timed, timed_next;
  logic [2:0]    phase_next;
  logic          vld_next;
  logic          ill_next, ord_next, tim_next;
  logic [15:0]   cyc_next;
  logic          new_illegal, new_order, new_timing, wrap;
  logic [DW-1:0] t_prev;

  always_comb begin
    t_prev = DW'(T_P1);
    case (prev)
      3'd1:    t_prev = DW'(T_P2);
      3'd2:    t_prev = DW'(T_P3);
      3'd3:    t_prev = DW'(T_P4);
      3'd4:    t_prev = DW'(T_P5);
      3'd5:    t_prev = DW'(T_P6);
      default: t_prev = DW'(T_P1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      prev        <= 3'(P1);
      dwell       <= '0;
      timed       <= 1'b1;
      phase       <= 3'd0;
      phase_vld   <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_timing  <= 1'b0;
      cycle_cnt   <= 16'd0;
    end else begin
      state       <= state_next;
      prev        <= prev_next;
      dwell       <= dwell_next;
      timed       <= timed_next;
      phase       <= phase_next;
      phase_vld   <= vld_next;
      err_illegal <= ill_next;
      err_order   <= ord_next;
      err_timing  <= tim_next;
      cycle_cnt   <= cyc_next;
    end
  end

  always_comb begin
    state_next  = state;
    prev_next   = prev;
    dwell_next  = dwell;
    timed_next  = timed;
    phase_next  = 3'd0;
    vld_next    = 1'b0;
    new_illegal = 1'b0;
    new_order   = 1'b0;
    new_timing  = 1'b0;
    wrap        = 1'b0;

    if (!legal) begin
      new_illegal = 1'b1;
      state_next  = SYNC;
      dwell_next  = '0;
      timed_next  = 1'b0;
    end else begin
      phase_next = dec_phase;
      vld_next   = 1'b1;
      state_next = TRACK;
      if (state == SYNC) begin
        prev_next  = dec_phase;
        dwell_next = DW'(1);
      end else if (dec_phase == prev) begin
        if (dwell != '1) dwell_next = dwell + DW'(1);
        // dwell keeps counting past T, so the equality fires only once
        if (timed && dwell == t_prev) new_timing = 1'b1;
      end else begin
        if (timed && dwell < t_prev) new_timing = 1'b1;
        if (dec_phase != next_phase(prev)) new_order = 1'b1;
        if (prev == P6 && dec_phase == P1 && !new_timing && !new_order) wrap = 1'b1;
        prev_next  = dec_phase;
        dwell_next = DW'(1);
        timed_next = 1'b1;
      end
    end

    // A new error on the clearing edge keeps its flag set
    ill_next = (err_illegal & ~clr_err) | new_illegal;
    ord_next = (err_order   & ~clr_err) | new_order;
    tim_next = (err_timing  & ~clr_err) | new_timing;
    cyc_next = cycle_cnt + 16'(wrap);
  end

`ifdef TLM_ERR_CAPTURE_EN
  logic [2:0]    cap_phase;
  logic [DW-1:0] cap_dwell;
  logic          any_new, any_held;

  assign any_new  = new_illegal | new_order | new_timing;
  assign any_held = (err_illegal | err_order | err_timing) & ~clr_err;

  // Captures the sampled phase and the dwell count reached when the error hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_phase <= 3'd0;
      cap_dwell <= '0;
    end else if (any_new && !any_held) begin
      cap_phase <= phase_next;
      cap_dwell <= dwell;
    end else if (clr_err) begin
      cap_phase <= 3'd0;
      cap_dwell <= '0;
    end
  end

  assign err_phase = cap_phase;
  assign err_dwell = cap_dwell;
`else
  assign err_phase = 3'd0;
  assign err_dwell = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_err = 1'b0;
  logic [2:0]  phase;
  logic        phase_vld, err_illegal, err_order, err_timing;
  logic [15:0] cycle_cnt;
  logic [2:0]  err_phase;
  logic [7:0]  err_dwell;

  traffic_light_monitor_if bus();

  traffic_light_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .lights      (bus),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_vld   (phase_vld),
    .err_illegal (err_illegal),
    .err_order   (err_order),
    .err_timing  (err_timing),
    .cycle_cnt   (cycle_cnt),
    .err_phase   (err_phase),
    .err_dwell   (err_dwell)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ph;
    logic        vld;
    logic        ill;
    logic        ord;
    logic        tim;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   tdw[6] = '{7, 2, 5, 2, 3, 2};

  function automatic logic [11:0] pat(input int p);
    case (p)
      0:       pat = {G, G, R, R};
      1:       pat = {G, A, R, R};
      2:       pat = {G, R, G, R};
      3:       pat = {A, R, A, R};
      4:       pat = {R, R, R, G};
      default: pat = {R, R, R, A};
    endcase
  endfunction

  // Apply one sample at the falling edge and queue what the next rising edge must show
  task automatic vec(input logic [11:0] lw, input logic c, input logic r,
                     input logic [2:0] ph, input logic vld, input logic ill,
                     input logic ord, input logic tim, input logic [15:0] cyc);
    exp_t e;
    @(negedge clk);
    {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S} = lw;
    clr_err = c;
    rst = r;
    e.ph = ph; e.vld = vld; e.ill = ill; e.ord = ord; e.tim = tim; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic ok(input int p, input int cyc);
    vec(pat(p), 1'b0, 1'b0, 3'(p), 1'b1, 1'b0, 1'b0, 1'b0, 16'(cyc));
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %0h expected %0h", n_vec, name, act, req);
    end
  endtask

  // Monitor: every rising edge presents a registered result for the queued sample
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        chk("phase",       16'(phase),       16'(e.ph));
        chk("phase_vld",   16'(phase_vld),   16'(e.vld));
        chk("err_illegal", 16'(err_illegal), 16'(e.ill));
        chk("err_order",   16'(err_order),   16'(e.ord));
        chk("err_timing",  16'(err_timing),  16'(e.tim));
        chk("cycle_cnt",   cycle_cnt,        e.cyc);
        $display("vec %0d: phase=%0d vld=%0b ill=%0b ord=%0b tim=%0b cyc=%0d",
                 n_vec, phase, phase_vld, err_illegal, err_order, err_timing, cycle_cnt);
      end
    end
  end

  initial begin
    logic [11:0] bad;
    bad = {3'b011, R, A, R};
    {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S} = pat(0);

    // Reset state
    repeat (2) vec(pat(0), 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Three full rotations with exact dwells, then the closing P6->P1
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < 6; p++)
        for (int d = 0; d < tdw[p]; d++)
          ok(p, r);
    ok(0, 3);

    // Hold P1 for 9 samples in total: overstay flagged on the 8th
    for (int k = 2; k <= 7; k++) ok(0, 3);
    repeat (2) vec(pat(0), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    vec(pat(1), 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    vec(pat(1), 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);

    // Leave P3 after 3 samples: understay on P4 entry, no order error
    repeat (3) ok(2, 3);
    vec(pat(3), 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    vec(pat(3), 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    repeat (3) ok(4, 3);
    repeat (2) ok(5, 3);
    repeat (7) ok(0, 4);

    // P1 -> P3 directly: order error, dwell restarts so a 5-sample P3 is on time
    repeat (5) vec(pat(2), 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
    vec(pat(3), 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
    vec(pat(3), 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);

    // Illegal lamp code, then resync into P5 whose dwell is not checked
    vec(bad, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    repeat (4) vec(pat(4), 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);
    repeat (2) vec(pat(5), 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4);
    vec(pat(0), 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5);

    // Clear on the same edge as a new illegal pattern: flag stays set
    vec(bad, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
    vec(pat(2), 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    vec(pat(2), 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);

    // Reset mid-P3 returns everything to zero, then tracking restarts
    vec(pat(2), 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    vec(pat(0), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d results pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
